// File: rtl/hdmi_acr_pkg.sv
// Shared constants and types for the HDMI Audio Clock Regeneration receiver.
package hdmi_acr_pkg;

    localparam logic [7:0] ACR_PACKET_TYPE = 8'h01;
    localparam int N_WIDTH   = 20;
    localparam int CTS_WIDTH = 20;
    localparam int SUBPKT_W  = 56;

    // Byte positions of the ACR fields inside a 56-bit subpacket (byte 0 reserved).
    localparam int CTS_HI_BYTE  = 1;
    localparam int CTS_MID_BYTE = 2;
    localparam int CTS_LO_BYTE  = 3;
    localparam int N_HI_BYTE    = 4;
    localparam int N_MID_BYTE   = 5;
    localparam int N_LO_BYTE    = 6;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } acr_state_e;

endpackage

// File: rtl/acr_clock_dda.sv
// First-order DDA producing a 128*fs clock enable (average rate f_pixel*N/CTS)
// plus a divide-by-128 fs enable coincident with every 128th 128*fs enable.
module acr_clock_dda
    import hdmi_acr_pkg::*;
(
    input  logic                 clk_pixel,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 run,
    input  logic [N_WIDTH-1:0]   n,
    input  logic [CTS_WIDTH-1:0] cts,
    output logic                 en_128fs,
    output logic                 en_fs
);

    logic [CTS_WIDTH:0] acc_q, acc_d;
    logic [CTS_WIDTH:0] sum;
    logic [6:0]         div_q, div_d;
    logic               en_128fs_q, en_128fs_d;
    logic               en_fs_q, en_fs_d;

    // Accumulate N each cycle; subtract CTS and emit an enable on overflow past CTS.
    always_comb begin
        acc_d      = acc_q;
        div_d      = div_q;
        en_128fs_d = 1'b0;
        en_fs_d    = 1'b0;
        sum        = acc_q + {1'b0, n};
        if (clear) begin
            acc_d = '0;
            div_d = '0;
        end else if (run) begin
            if (sum >= {1'b0, cts}) begin
                acc_d      = sum - {1'b0, cts};
                en_128fs_d = 1'b1;
                en_fs_d    = (div_q == 7'd127);
                div_d      = div_q + 7'd1;
            end else begin
                acc_d = sum;
            end
        end
    end

    // Accumulator, divider and enable registers.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            acc_q      <= '0;
            div_q      <= '0;
            en_128fs_q <= 1'b0;
            en_fs_q    <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            div_q      <= div_d;
            en_128fs_q <= en_128fs_d;
            en_fs_q    <= en_fs_d;
        end
    end

    assign en_128fs = en_128fs_q;
    assign en_fs    = en_fs_q;

endmodule

// File: rtl/audio_clock_regeneration_receiver.sv
// HDMI sink ACR receiver: parses ACR packets for N/CTS, tracks lock, and
// regenerates 128*fs and fs clock enables in the clk_pixel domain.
// Optional build macro ACR_SUBPACKET_CHECK_EN: reject packets whose four
// subpackets are not bit-identical.
module audio_clock_regeneration_receiver
    import hdmi_acr_pkg::*;
#(
    parameter int                   LOCK_PACKETS   = 3,
    parameter logic [CTS_WIDTH-1:0] CTS_TOLERANCE  = 20'd16,
    parameter int                   TIMEOUT_CYCLES = 262144
) (
    input  logic                 clk_pixel,
    input  logic                 reset,
    input  logic                 packet_valid,
    input  logic [23:0]          header,
    input  logic [223:0]         sub,
    output logic [N_WIDTH-1:0]   n,
    output logic [CTS_WIDTH-1:0] cts,
    output logic                 cts_update,
    output logic                 packet_error,
    output logic                 locked,
    output logic                 audio_128fs_en,
    output logic                 audio_fs_en
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    acr_state_e           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [N_WIDTH-1:0]   n_q, n_d;
    logic [CTS_WIDTH-1:0] cts_q, cts_d;
    logic                 cts_update_q, cts_update_d;
    logic                 packet_error_q, packet_error_d;
    logic                 locked_q, locked_d;

    logic [SUBPKT_W-1:0]  sp0;
    logic [N_WIDTH-1:0]   pkt_n;
    logic [CTS_WIDTH-1:0] pkt_cts;
    logic [CTS_WIDTH-1:0] cts_diff;
    logic                 is_acr, sub_mismatch, bad, accept, reject;
    logic                 n_same, consistent, tmo_fire, dda_clear;
    logic                 dda_en_128fs, dda_en_fs;
    logic                 unused_bits;

    // Field extraction and packet classification.
    always_comb begin
        sp0     = sub[SUBPKT_W-1:0];
        pkt_cts = {sp0[8*CTS_HI_BYTE +: 4], sp0[8*CTS_MID_BYTE +: 8], sp0[8*CTS_LO_BYTE +: 8]};
        pkt_n   = {sp0[8*N_HI_BYTE +: 4], sp0[8*N_MID_BYTE +: 8], sp0[8*N_LO_BYTE +: 8]};
        is_acr  = packet_valid && (header[7:0] == ACR_PACKET_TYPE);
`ifdef ACR_SUBPACKET_CHECK_EN
        sub_mismatch = (sub[2*SUBPKT_W-1:SUBPKT_W]   != sp0) ||
                       (sub[3*SUBPKT_W-1:2*SUBPKT_W] != sp0) ||
                       (sub[4*SUBPKT_W-1:3*SUBPKT_W] != sp0);
        unused_bits  = ^{header[23:8], sp0[7:0], sp0[15:12], sp0[39:36]};
`else
        sub_mismatch = 1'b0;
        unused_bits  = ^{header[23:8], sp0[7:0], sp0[15:12], sp0[39:36], sub[223:SUBPKT_W]};
`endif
        bad        = (pkt_n == '0) || (pkt_cts == '0) || (pkt_n > pkt_cts) || sub_mismatch;
        accept     = is_acr && !bad;
        reject     = is_acr && bad;
        n_same     = (pkt_n == n_q);
        cts_diff   = (pkt_cts >= cts_q) ? (pkt_cts - cts_q) : (cts_q - pkt_cts);
        consistent = n_same && (cts_diff <= CTS_TOLERANCE);
        tmo_fire   = !accept && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    end

    // Next-state logic for lock tracking, consistency count and timeout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q + TMO_W'(1);
        dda_clear = 1'b0;
        if (accept) begin
            tmo_d = '0;
            case (state_q)
                UNLOCKED: begin
                    cnt_d   = 4'd1;
                    state_d = (LOCK_PACKETS <= 1) ? LOCKED : ACQUIRE;
                end
                ACQUIRE: begin
                    if (consistent) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 >= 4'(LOCK_PACKETS)) state_d = LOCKED;
                    end else begin
                        cnt_d = 4'd1;
                    end
                end
                LOCKED: begin
                    if (!consistent) begin
                        cnt_d   = 4'd1;
                        state_d = (LOCK_PACKETS <= 1) ? LOCKED : ACQUIRE;
                        // A new N means a new audio rate: restart DDA phase.
                        dda_clear = !n_same;
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end else if (tmo_fire) begin
            tmo_d     = '0;
            cnt_d     = '0;
            state_d   = UNLOCKED;
            dda_clear = 1'b1;
        end
    end

    // Output decode: registered field values, strobes and lock flag.
    always_comb begin
        n_d            = accept ? pkt_n : n_q;
        cts_d          = accept ? pkt_cts : cts_q;
        cts_update_d   = accept;
        packet_error_d = reject;
        locked_d       = (state_d == LOCKED);
    end

    // State and output registers.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q        <= UNLOCKED;
            cnt_q          <= '0;
            tmo_q          <= '0;
            n_q            <= '0;
            cts_q          <= '0;
            cts_update_q   <= 1'b0;
            packet_error_q <= 1'b0;
            locked_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            tmo_q          <= tmo_d;
            n_q            <= n_d;
            cts_q          <= cts_d;
            cts_update_q   <= cts_update_d;
            packet_error_q <= packet_error_d;
            locked_q       <= locked_d;
        end
    end

    acr_clock_dda u_dda (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .clear     (dda_clear),
        .run       (state_q != UNLOCKED),
        .n         (n_q),
        .cts       (cts_q),
        .en_128fs  (dda_en_128fs),
        .en_fs     (dda_en_fs)
    );

    assign n              = n_q;
    assign cts            = cts_q;
    assign cts_update     = cts_update_q;
    assign packet_error   = packet_error_q;
    assign locked         = locked_q;
    assign audio_128fs_en = dda_en_128fs && locked_q;
    assign audio_fs_en    = dda_en_fs && locked_q;

endmodule

// File: tb/tb_audio_clock_regeneration_receiver.sv
// Directed testbench for audio_clock_regeneration_receiver.
module tb_audio_clock_regeneration_receiver;

    localparam int TMO = 4096;

    logic         clk_pixel = 1'b0;
    logic         reset;
    logic         packet_valid;
    logic [23:0]  header;
    logic [223:0] sub;
    logic [19:0]  n;
    logic [19:0]  cts;
    logic         cts_update;
    logic         packet_error;
    logic         locked;
    logic         audio_128fs_en;
    logic         audio_fs_en;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_pixel = ~clk_pixel;

    audio_clock_regeneration_receiver #(
        .LOCK_PACKETS   (3),
        .CTS_TOLERANCE  (20'd16),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_pixel      (clk_pixel),
        .reset          (reset),
        .packet_valid   (packet_valid),
        .header         (header),
        .sub            (sub),
        .n              (n),
        .cts            (cts),
        .cts_update     (cts_update),
        .packet_error   (packet_error),
        .locked         (locked),
        .audio_128fs_en (audio_128fs_en),
        .audio_fs_en    (audio_fs_en)
    );

    // Subpacket layout: byte0 reserved, bytes1..3 CTS (hi nibble, mid, lo), bytes4..6 N.
    function automatic logic [223:0] mk_sub(input logic [19:0] nv, input logic [19:0] cv);
        logic [55:0] sp;
        sp = {nv[7:0], nv[15:8], {4'h0, nv[19:16]}, cv[7:0], cv[15:8], {4'h0, cv[19:16]}, 8'h00};
        return {sp, sp, sp, sp};
    endfunction

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic send(input logic [7:0] typ, input logic [223:0] s);
        header       = {16'h0, typ};
        sub          = s;
        packet_valid = 1'b1;
        tick();
        packet_valid = 1'b0;
    endtask

    task automatic acr(input logic [19:0] nv, input logic [19:0] cv);
        send(8'h01, mk_sub(nv, cv));
    endtask

    // Count enables over a window, refreshing the same N/CTS every 2000 cycles.
    task automatic count_window(input int cycles, input logic [19:0] nv, input logic [19:0] cv,
                                output int c128, output int cfs, output int bad);
        c128 = 0; cfs = 0; bad = 0;
        header = 24'h000001;
        sub    = mk_sub(nv, cv);
        for (int i = 0; i < cycles; i++) begin
            packet_valid = ((i % 2000) == 1999);
            if (audio_128fs_en) c128++;
            if (audio_fs_en) cfs++;
            if (!locked || (audio_fs_en && !audio_128fs_en)) bad++;
            tick();
        end
        packet_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        packet_valid = 1'b0;
        repeat (3) tick();
        acr(20'd6144, 20'd25200);
        n_checks++;
        if ({n, cts, cts_update, packet_error, locked, audio_128fs_en, audio_fs_en} !== 45'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got n=%0d cts=%0d upd=%b err=%b lk=%b, required all 0", n, cts, cts_update, packet_error, locked);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (locked !== 1'b0 || n !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_release: got locked=%b n=%0d, required 0 0", locked, n);
        end
    endtask

    task automatic test_lock_48k();
        int c128, cfs, bad;
        acr(20'd6144, 20'd25200);
        n_checks++;
        if (cts_update !== 1'b1 || n !== 20'd6144 || cts !== 20'd25200 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL first_accept: got upd=%b n=%0d cts=%0d lk=%b, required 1 6144 25200 0", cts_update, n, cts, locked);
        end
        acr(20'd6144, 20'd25200);
        n_checks++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_after_2: got %b, required 0", locked);
        end
        acr(20'd6144, 20'd25200);
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_after_3: got %b, required 1", locked);
        end
        count_window(25200, 20'd6144, 20'd25200, c128, cfs, bad);
        n_checks++;
        if (c128 !== 6144) begin
            n_fail++;
            $display("FAIL count_128fs_48k: got %0d, required 6144", c128);
        end
        n_checks++;
        if (cfs !== 48) begin
            n_fail++;
            $display("FAIL count_fs_48k: got %0d, required 48", cfs);
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL window_48k_lock: got %0d bad cycles, required 0", bad);
        end
    endtask

    task automatic test_cts_tolerance();
        acr(20'd6144, 20'd25210);
        n_checks++;
        if (locked !== 1'b1 || cts !== 20'd25210) begin
            n_fail++;
            $display("FAIL cts_within_tol: got lk=%b cts=%0d, required 1 25210", locked, cts);
        end
        acr(20'd6144, 20'd25230);
        n_checks++;
        if (locked !== 1'b0 || cts !== 20'd25230) begin
            n_fail++;
            $display("FAIL cts_beyond_tol: got lk=%b cts=%0d, required 0 25230", locked, cts);
        end
        acr(20'd6144, 20'd25230);
        n_checks++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL relock_after_1: got %b, required 0", locked);
        end
        acr(20'd6144, 20'd25230);
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL relock_after_2: got %b, required 1", locked);
        end
    endtask

    task automatic test_n_change();
        int c128, cfs, bad;
        acr(20'd5880, 20'd25200);
        n_checks++;
        if (locked !== 1'b0 || n !== 20'd5880 || audio_128fs_en !== 1'b0) begin
            n_fail++;
            $display("FAIL n_change_unlock: got lk=%b n=%0d en=%b, required 0 5880 0", locked, n, audio_128fs_en);
        end
        acr(20'd5880, 20'd25200);
        acr(20'd5880, 20'd25200);
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL n_change_relock: got %b, required 1", locked);
        end
        count_window(25200, 20'd5880, 20'd25200, c128, cfs, bad);
        n_checks++;
        if (c128 !== 5880) begin
            n_fail++;
            $display("FAIL count_128fs_44k1: got %0d, required 5880", c128);
        end
        n_checks++;
        if (cfs !== 45) begin
            n_fail++;
            $display("FAIL count_fs_44k1: got %0d, required 45", cfs);
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL window_44k1_lock: got %0d bad cycles, required 0", bad);
        end
    endtask

    task automatic test_errors();
        logic [19:0] nv [3];
        logic [19:0] cv [3];
        nv[0] = 20'd0;     cv[0] = 20'd25200;
        nv[1] = 20'd5880;  cv[1] = 20'd0;
        nv[2] = 20'd30000; cv[2] = 20'd25200;
        for (int i = 0; i < 3; i++) begin
            acr(nv[i], cv[i]);
            n_checks++;
            if (packet_error !== 1'b1 || cts_update !== 1'b0 || n !== 20'd5880 || cts !== 20'd25200 || locked !== 1'b1) begin
                n_fail++;
                $display("FAIL reject_%0d: got err=%b upd=%b n=%0d cts=%0d lk=%b, required 1 0 5880 25200 1",
                         i, packet_error, cts_update, n, cts, locked);
            end
        end
        send(8'h02, mk_sub(20'd100, 20'd200));
        n_checks++;
        if (packet_error !== 1'b0 || cts_update !== 1'b0 || n !== 20'd5880) begin
            n_fail++;
            $display("FAIL non_acr_ignored: got err=%b upd=%b n=%0d, required 0 0 5880", packet_error, cts_update, n);
        end
    endtask

    task automatic test_timeout();
        int c128, cfs, bad;
        acr(20'd5880, 20'd25200);
        repeat (1000) tick();
        acr(20'd0, 20'd25200);
        n_checks++;
        if (packet_error !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_reject_pulse: got %b, required 1", packet_error);
        end
        repeat (TMO - 1 - 1001) tick();
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_early: got %b, required 1", locked);
        end
        tick();
        n_checks++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_drop: got %b, required 0", locked);
        end
        c128 = 0; cfs = 0;
        for (int i = 0; i < 500; i++) begin
            if (audio_128fs_en) c128++;
            if (audio_fs_en) cfs++;
            tick();
        end
        n_checks++;
        if (c128 !== 0 || cfs !== 0) begin
            n_fail++;
            $display("FAIL timeout_enables: got %0d/%0d pulses, required 0/0", c128, cfs);
        end
        acr(20'd5880, 20'd25200);
        acr(20'd5880, 20'd25200);
        acr(20'd5880, 20'd25200);
        repeat (TMO - 1) tick();
        acr(20'd5880, 20'd25200);
        n_checks++;
        if (locked !== 1'b1 || cts_update !== 1'b1) begin
            n_fail++;
            $display("FAIL packet_on_timeout: got lk=%b upd=%b, required 1 1", locked, cts_update);
        end
        repeat (TMO - 1) tick();
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_restart_early: got %b, required 1", locked);
        end
        tick();
        n_checks++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_restart_drop: got %b, required 0", locked);
        end
        count_window(100, 20'd0, 20'd1, c128, cfs, bad);
    endtask

    task automatic test_subpacket();
        logic [223:0] s;
        acr(20'd5880, 20'd25200);
        acr(20'd5880, 20'd25200);
        acr(20'd5880, 20'd25200);
        s = mk_sub(20'd5880, 20'd25205);
        s[2*56 + 9] = ~s[2*56 + 9];
        send(8'h01, s);
`ifdef ACR_SUBPACKET_CHECK_EN
        n_checks++;
        if (packet_error !== 1'b1 || cts_update !== 1'b0 || cts !== 20'd25200) begin
            n_fail++;
            $display("FAIL subpkt_mismatch: got err=%b upd=%b cts=%0d, required 1 0 25200", packet_error, cts_update, cts);
        end
`else
        n_checks++;
        if (packet_error !== 1'b0 || cts_update !== 1'b1 || cts !== 20'd25205 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL subpkt_ignored: got err=%b upd=%b cts=%0d lk=%b, required 0 1 25205 1", packet_error, cts_update, cts, locked);
        end
`endif
    endtask

    task automatic test_reset_midop();
        int c128;
        reset = 1'b1;
        acr(20'd1000, 20'd2000);
        n_checks++;
        if (locked !== 1'b0 || n !== 20'd0 || cts !== 20'd0 || cts_update !== 1'b0 || audio_128fs_en !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_reset: got lk=%b n=%0d cts=%0d upd=%b, required 0 0 0 0", locked, n, cts, cts_update);
        end
        reset = 1'b0;
        c128 = 0;
        for (int i = 0; i < 50; i++) begin
            if (audio_128fs_en || locked) c128++;
            tick();
        end
        n_checks++;
        if (c128 !== 0 || n !== 20'd0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %0d active cycles n=%0d, required 0 0", c128, n);
        end
    endtask

    initial begin
        reset        = 1'b1;
        packet_valid = 1'b0;
        header       = '0;
        sub          = '0;
        test_reset();
        test_lock_48k();
        test_cts_tolerance();
        test_n_change();
        test_errors();
        test_timeout();
        test_subpacket();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
